// File: rtl/polyphonic_player.sv
// Polyphonic clip player: mixes NUM_VOICES linearly interpolated voices from a
// shared clip memory into one saturated 16-bit sample per sample_tick.
module polyphonic_player #(
  parameter int CLIP_LEN   = 1024,
  parameter int NUM_VOICES = 4,
  parameter int FRAC_BITS  = 8,
  parameter int IDX_W      = $clog2(CLIP_LEN),
  parameter int PH_W       = IDX_W + FRAC_BITS
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
  input  logic [PH_W-1:0]               cfg_inc,
  input  logic                          cfg_loop,
  input  logic                          cfg_gate,
  output logic [IDX_W-1:0]              mem_addr,
  input  logic signed [15:0]            mem_data,
  output logic signed [15:0]            player_sample,
  output logic                          valid,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic                          overrun
);

  localparam int VW     = $clog2(NUM_VOICES);
  localparam int ACC_W  = 16 + VW + 1;
  localparam int PROD_W = 17 + FRAC_BITS + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {IDLE, RD0, RD1, MAC, OUT} state_e;

  state_e                         state_q, state_d;
  logic [VW-1:0]                  v_q, v_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [15:0]             s0_q, s0_d;
  logic signed [15:0]             sample_q, sample_d;
  logic                           overrun_q, overrun_d;
  logic [NUM_VOICES-1:0][PH_W-1:0] phase_q, phase_d;
  logic [NUM_VOICES-1:0][PH_W-1:0] inc_q, inc_d;
  logic [NUM_VOICES-1:0]          loop_q, loop_d;
  logic [NUM_VOICES-1:0]          active_q, active_d;

  logic [PH_W-1:0]                curPhase;
  logic [IDX_W-1:0]               idx, idxNext;
  logic [FRAC_BITS-1:0]           frac;
  logic signed [16:0]             diff;
  logic signed [PROD_W-1:0]       prod, shifted;
  logic signed [ACC_W-1:0]        interp;
  logic [PH_W:0]                  phaseSum;

  function automatic logic signed [15:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX) return 16'h7fff;
    if (a < SAT_MIN) return 16'h8000;
    return a[15:0];
  endfunction

  // Datapath for the voice currently addressed by v_q.
  always_comb begin
    curPhase = phase_q[v_q];
    idx      = curPhase[PH_W-1:FRAC_BITS];
    frac     = curPhase[FRAC_BITS-1:0];
    if (idx == IDX_W'(CLIP_LEN - 1)) idxNext = loop_q[v_q] ? '0 : idx;
    else                             idxNext = idx + 1'b1;
    diff     = {mem_data[15], mem_data} - {s0_q[15], s0_q};
    prod     = PROD_W'(diff) * PROD_W'($signed({1'b0, frac}));
    shifted  = prod >>> FRAC_BITS;
    interp   = ACC_W'(s0_q) + ACC_W'(shifted);
    phaseSum = {1'b0, curPhase} + {1'b0, inc_q[v_q]};
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    acc_d     = acc_q;
    s0_d      = s0_q;
    sample_d  = sample_q;
    overrun_d = overrun_q;
    phase_d   = phase_q;
    inc_d     = inc_q;
    loop_d    = loop_q;
    active_d  = active_q;
    mem_addr  = '0;
    valid     = 1'b0;
    cfg_ready = 1'b0;
    if (sample_tick && state_q != IDLE) overrun_d = 1'b1;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          inc_d[cfg_voice]    = cfg_inc;
          loop_d[cfg_voice]   = cfg_loop;
          active_d[cfg_voice] = cfg_gate;
          if (cfg_gate) phase_d[cfg_voice] = '0;
        end
        if (sample_tick) begin
          acc_d   = '0;
          v_d     = '0;
          state_d = RD0;
        end
      end
      RD0: begin
        mem_addr = idx;
        state_d  = RD1;
      end
      RD1: begin
        mem_addr = idxNext;
        s0_d     = mem_data;
        state_d  = MAC;
      end
      MAC: begin
        if (active_q[v_q]) begin
          acc_d = acc_q + interp;
          if (loop_q[v_q]) begin
            phase_d[v_q] = phaseSum[PH_W-1:0];
          end else if (phaseSum[PH_W]) begin
            active_d[v_q] = 1'b0;
            phase_d[v_q]  = '0;
          end else begin
            phase_d[v_q] = phaseSum[PH_W-1:0];
          end
        end
        // The result is latched as OUT is entered so it lines up with valid.
        if (v_q == VW'(NUM_VOICES - 1)) begin
          sample_d = saturate(acc_d);
          state_d  = OUT;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = RD0;
        end
      end
      OUT: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q   <= IDLE;
      v_q       <= '0;
      acc_q     <= '0;
      s0_q      <= '0;
      sample_q  <= '0;
      overrun_q <= 1'b0;
      phase_q   <= '0;
      inc_q     <= '0;
      loop_q    <= '0;
      active_q  <= '0;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      acc_q     <= acc_d;
      s0_q      <= s0_d;
      sample_q  <= sample_d;
      overrun_q <= overrun_d;
      phase_q   <= phase_d;
      inc_q     <= inc_d;
      loop_q    <= loop_d;
      active_q  <= active_d;
    end
  end

  assign player_sample = sample_q;
  assign voice_active  = active_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_polyphonic_player.sv
// Self-checking bench for polyphonic_player: directed scenarios plus random
// voices, all compared against a per-voice phase/interpolation reference model.
module tb_polyphonic_player;

  localparam int CLIP_LEN   = 1024;
  localparam int NUM_VOICES = 4;
  localparam int FRAC_BITS  = 8;
  localparam int IDX_W      = 10;
  localparam int PH_W       = 18;
  localparam int SCALE      = 1 << FRAC_BITS;
  localparam int PH_MOD     = CLIP_LEN * SCALE;
  localparam int LAT        = 3 * NUM_VOICES + 1;

  logic                    mclk = 1'b0;
  logic                    rst;
  logic                    sample_tick;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [1:0]              cfg_voice;
  logic [PH_W-1:0]         cfg_inc;
  logic                    cfg_loop;
  logic                    cfg_gate;
  logic [IDX_W-1:0]        mem_addr;
  logic signed [15:0]      mem_data;
  logic signed [15:0]      player_sample;
  logic                    valid;
  logic [NUM_VOICES-1:0]   voice_active;
  logic                    overrun;

  int compCount = 0;
  int errCount  = 0;
  int mem [CLIP_LEN];
  int mPhase [NUM_VOICES];
  int mInc [NUM_VOICES];
  bit mLoop [NUM_VOICES];
  bit mActive [NUM_VOICES];
  int expSample, lastLat, rd0Addr, validCount, validAt;

  polyphonic_player dut (
    .mclk(mclk), .rst(rst), .sample_tick(sample_tick),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_voice(cfg_voice),
    .cfg_inc(cfg_inc), .cfg_loop(cfg_loop), .cfg_gate(cfg_gate),
    .mem_addr(mem_addr), .mem_data(mem_data), .player_sample(player_sample),
    .valid(valid), .voice_active(voice_active), .overrun(overrun)
  );

  always #5 mclk = ~mclk;

  // Synchronous clip memory: data appears one mclk after the address.
  always @(posedge mclk) mem_data <= 16'(mem[mem_addr]);

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    compCount++;
    assert (obs === exp) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floorDiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NUM_VOICES; i++) begin
      mPhase[i] = 0; mInc[i] = 0; mLoop[i] = 0; mActive[i] = 0;
    end
  endfunction

  function automatic void modelCfg(input int voice, input int inc, input bit loopF, input bit gate);
    mInc[voice]    = inc;
    mLoop[voice]   = loopF;
    mActive[voice] = gate;
    if (gate) mPhase[voice] = 0;
  endfunction

  // One output sample from the current voice settings; advances every active voice.
  function automatic int modelTick();
    int acc = 0;
    for (int vc = 0; vc < NUM_VOICES; vc++) begin
      int idx  = mPhase[vc] / SCALE;
      int frac = mPhase[vc] % SCALE;
      int idx1 = idx + 1;
      int nxt;
      if (idx1 == CLIP_LEN) idx1 = mLoop[vc] ? 0 : CLIP_LEN - 1;
      if (mActive[vc]) begin
        acc += mem[idx] + floorDiv((mem[idx1] - mem[idx]) * frac, SCALE);
        nxt = mPhase[vc] + mInc[vc];
        if (mLoop[vc]) mPhase[vc] = nxt % PH_MOD;
        else if (nxt >= PH_MOD) begin mActive[vc] = 0; mPhase[vc] = 0; end
        else mPhase[vc] = nxt;
      end
    end
    if (acc > 32767) return 32767;
    if (acc < -32768) return -32768;
    return acc;
  endfunction

  task automatic fillMem(input int value);
    for (int i = 0; i < CLIP_LEN; i++) mem[i] = value;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_sample"}, player_sample, 0);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_overrun"}, overrun, 0);
    checkOutput({tag, "_addr"}, mem_addr, 0);
    checkOutput({tag, "_ready"}, cfg_ready, 1);
    checkOutput({tag, "_active"}, voice_active, 0);
  endtask

  // One IDLE cycle of stimulus; a tick waits (bounded) for valid and checks the result.
  task automatic applyStimulus(input bit doCfg, input int voice, input int inc, input bit loopF,
                               input bit gate, input bit doTick, input string tag);
    @(negedge mclk);
    cfg_valid   = doCfg;
    cfg_voice   = 2'(voice);
    cfg_inc     = PH_W'(inc);
    cfg_loop    = loopF;
    cfg_gate    = gate;
    sample_tick = doTick;
    if (doCfg) begin
      checkOutput({tag, "_ready"}, cfg_ready, 1);
      modelCfg(voice, inc, loopF, gate);
    end
    if (doTick) expSample = modelTick();
    @(negedge mclk);
    cfg_valid   = 1'b0;
    sample_tick = 1'b0;
    if (doTick) begin
      rd0Addr = mem_addr;
      lastLat = 1;
      while (!valid && lastLat < LAT + 10) begin
        @(negedge mclk);
        lastLat++;
      end
      checkOutput({tag, "_lat"}, lastLat, LAT);
      checkOutput({tag, "_sample"}, player_sample, expSample);
    end
  endtask

  task automatic tick(input string tag);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; sample_tick = 1'b0; cfg_valid = 1'b0; cfg_voice = '0;
    cfg_inc = '0; cfg_loop = 1'b0; cfg_gate = 1'b0;
    for (int i = 0; i < CLIP_LEN; i++) mem[i] = i;
    modelReset();
    repeat (3) @(negedge mclk);
    checkResetState("reset");
    rst = 1'b0;

    $display("[TB] ramp, loop, inc 1.0");
    applyStimulus(1'b1, 0, 256, 1'b1, 1'b1, 1'b0, "rampCfg");
    for (int k = 0; k < 4; k++) begin
      tick("ramp");
      checkOutput("rampValue", player_sample, k);
    end
    repeat (3) @(negedge mclk);
    checkOutput("holdSample", player_sample, 3);
    checkOutput("holdValid", valid, 0);

    $display("[TB] half-step interpolation");
    mem[1] = 1000;
    applyStimulus(1'b1, 0, 128, 1'b1, 1'b1, 1'b0, "halfCfg");
    tick("half"); checkOutput("half0", player_sample, 0);
    tick("half"); checkOutput("half1", player_sample, 500);
    tick("half"); checkOutput("half2", player_sample, 1000);
    mem[1] = 1;

    $display("[TB] zero increment");
    mem[0] = -1234;
    applyStimulus(1'b1, 0, 0, 1'b1, 1'b1, 1'b0, "zeroCfg");
    for (int k = 0; k < 3; k++) begin
      tick("zeroInc");
      checkOutput("zeroIncValue", player_sample, -1234);
    end
    checkOutput("zeroIncActive", voice_active, 4'b0001);
    mem[0] = 0;

    $display("[TB] one-shot run to clip end");
    applyStimulus(1'b1, 0, 256, 1'b0, 1'b1, 1'b0, "oneShotCfg");
    for (int k = 0; k < 1022; k++) tick("oneShotRun");
    tick("oneShot1022"); checkOutput("oneShot1022Value", player_sample, 1022);
    tick("oneShot1023"); checkOutput("oneShot1023Value", player_sample, 1023);
    checkOutput("oneShotDone", voice_active, 0);
    tick("oneShotIdle"); checkOutput("oneShotIdleValue", player_sample, 0);

    $display("[TB] loop wrap across clip end");
    mem[1023] = 100; mem[0] = 300;
    applyStimulus(1'b1, 0, 320, 1'b1, 1'b1, 1'b0, "wrapCfg");
    for (int k = 0; k < 1639; k++) tick("wrapRun");
    checkOutput("wrapIdx", rd0Addr, 1023);
    checkOutput("wrapValue", player_sample, 200);
    tick("wrapNext");
    checkOutput("wrapNextIdx", rd0Addr, 0);
    for (int i = 0; i < CLIP_LEN; i++) mem[i] = i;

    $display("[TB] config and tick in the same cycle");
    applyStimulus(1'b1, 2, 512, 1'b1, 1'b1, 1'b1, "cfgTick");
    checkOutput("cfgTickActive", voice_active[2], 1);
    applyStimulus(1'b1, 0, 700, 1'b0, 1'b0, 1'b1, "gateOff");
    checkOutput("gateOffActive", voice_active[0], 0);

    $display("[TB] random voices");
    for (int i = 0; i < CLIP_LEN; i++) mem[i] = int'($urandom_range(0, 65535)) - 32768;
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, k, int'($urandom_range(0, 4096)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, "rndInit");
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 2) == 0)
        applyStimulus(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 4096)),
                      1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b1, "rndCfgTick");
      else
        tick("rndTick");
    end

    $display("[TB] saturation");
    fillMem(32767);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, k, int'($urandom_range(0, 2048)), 1'b1, 1'b1, 1'b0, "satCfg");
    tick("satHigh"); checkOutput("satHighValue", player_sample, 32767);
    fillMem(-32768);
    tick("satLow"); checkOutput("satLowValue", player_sample, -32768);

    $display("[TB] tick while busy");
    @(negedge mclk); sample_tick = 1'b1; expSample = modelTick();
    @(negedge mclk); sample_tick = 1'b0;
    @(negedge mclk); sample_tick = 1'b1;
    @(negedge mclk); sample_tick = 1'b0;
    validCount = 0; validAt = 0;
    for (int c = 3; c <= 30; c++) begin
      if (valid) begin
        validCount++;
        validAt = c;
        checkOutput("busySample", player_sample, expSample);
      end
      @(negedge mclk);
    end
    checkOutput("busyValidCount", validCount, 1);
    checkOutput("busyValidAt", validAt, LAT);
    checkOutput("busyOverrun", overrun, 1);

    $display("[TB] reset during MAC");
    @(negedge mclk); sample_tick = 1'b1;
    @(negedge mclk); sample_tick = 1'b0;
    @(negedge mclk);
    @(negedge mclk); rst = 1'b1;
    @(negedge mclk);
    checkResetState("rstMac");
    rst = 1'b0;
    modelReset();
    validCount = 0;
    for (int c = 0; c < 20; c++) begin
      if (valid) validCount++;
      @(negedge mclk);
    end
    checkOutput("rstNoValid", validCount, 0);
    applyStimulus(1'b1, 1, 300, 1'b1, 1'b1, 1'b0, "postRstCfg");
    tick("postRst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule

// File: doc/polyphonic_player.md
POLYPHONIC_PLAYER -- requirements
Module: polyphonic_player

Interface
REQ-001 Parameters (name, default, meaning):
- CLIP_LEN, 1024, clip memory depth in samples; SHALL be a power of 2.
- NUM_VOICES, 4, number of voices.
- FRAC_BITS, 8, phase fractional bits.
- IDX_W, $clog2(CLIP_LEN), integer index width.
- PH_W, IDX_W+FRAC_BITS, phase and increment width.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- mclk, in, 1: master clock (256x sample rate).
- rst, in, 1: synchronous, active-high reset.
- sample_tick, in, 1: one-mclk pulse that starts one output sample computation.
- cfg_valid, in, 1: voice configuration write request.
- cfg_ready, out, 1: configuration write accepted when high together with cfg_valid.
- cfg_voice, in, $clog2(NUM_VOICES): target voice.
- cfg_inc, in, PH_W: phase increment (unsigned Q IDX_W.FRAC_BITS).
- cfg_loop, in, 1: 1 = loop, 0 = one-shot.
- cfg_gate, in, 1: 1 = note on (phase reset to 0, voice active); 0 = note off (voice inactive).
- mem_addr, out, IDX_W: clip memory read address.
- mem_data, in, 16: signed sample returned exactly 1 mclk after mem_addr.
- player_sample, out, 16: signed, mixed, interpolated output.
- valid, out, 1: one-mclk pulse when player_sample updates.
- voice_active, out, NUM_VOICES: per-voice active flags.
- overrun, out, 1: sticky; set on sample_tick while busy.

Function
REQ-003 States: IDLE, RD0, RD1, MAC, OUT; the voice counter v SHALL run from 0 to NUM_VOICES-1.
REQ-004 In IDLE, sample_tick SHALL clear the accumulator, set v=0 and go to RD0.
REQ-005 RD0 SHALL drive mem_addr = phase[v] integer part (idx).
REQ-006 RD1 SHALL drive mem_addr = idx+1, with the following wrap rules:
- loop voice: wraps to 0 at CLIP_LEN-1.
- one-shot voice: held at CLIP_LEN-1.
REQ-007 RD1 SHALL capture s0 from mem_data; MAC SHALL capture s1 from mem_data.
REQ-008 MAC SHALL compute interp = s0 + (((s1 - s0) * frac) >>> FRAC_BITS), with 17-bit signed difference and no loss before the shift.
REQ-009 MAC SHALL add interp to a signed accumulator of 16+$clog2(NUM_VOICES)+1 bits only if voice v is active; an inactive voice SHALL add 0.
REQ-010 MAC SHALL update the phase of an active voice as follows:
- loop: phase += inc, modulo CLIP_LEN*2^FRAC_BITS.
- one-shot: if phase+inc >= CLIP_LEN*2^FRAC_BITS, clear active and phase to 0; otherwise phase += inc.
REQ-011 After MAC, the block SHALL go to RD0 with v+1 if v < NUM_VOICES-1, otherwise to OUT.
REQ-012 OUT SHALL register player_sample = accumulator saturated to [-32768, 32767], pulse valid for 1 cycle, and return to IDLE.
REQ-013 Latency SHALL be fixed at 3*NUM_VOICES+1 mclks from the sample_tick cycle to the valid cycle, independent of how many voices are active.
REQ-014 player_sample SHALL hold its value between valid pulses.
REQ-015 sample_tick in any state other than IDLE SHALL be ignored and SHALL set overrun; only rst clears overrun.
REQ-016 cfg_ready SHALL be 1 only in IDLE; a write SHALL occur on cfg_valid & cfg_ready and take effect the next cycle.
REQ-017 A cfg write and a sample_tick in the same IDLE cycle SHALL both be accepted, and the computation SHALL use the newly written voice settings.
REQ-018 A gate-on write to an already active voice SHALL retrigger it (phase 0); a gate-off write SHALL leave inc and loop stored.
REQ-019 inc = 0 on an active voice SHALL output s0 constantly without deactivating the voice.

Reset
REQ-020 On rst high at a mclk edge, all of the following SHALL hold on the next cycle, including when reset arrives mid-computation:
- state = IDLE, v = 0, accumulator = 0.
- all phases, incs and loop flags = 0; voice_active = 0.
- player_sample = 0, valid = 0, overrun = 0, mem_addr = 0, cfg_ready = 1.
REQ-021 No valid pulse SHALL be produced for a computation aborted by reset.

Verification
REQ-022 Single voice, loop, inc = 1.0 (256), ramp memory mem[i] = i: 4 ticks -> player_sample 0, 1, 2, 3; valid appears 3*NUM_VOICES+1 cycles after each tick.
REQ-023 inc = 0.5 (128), mem[0] = 0, mem[1] = 1000 -> outputs 0, 500, 1000.
REQ-024 Loop wrap with CLIP_LEN = 1024, phase at index 1023 with frac 0.5, mem[1023] = 100, mem[0] = 300 -> output 200, and the next phase is in index 0.
REQ-025 One-shot voice, inc = 1.0, started at index 1022 -> outputs mem[1022] and mem[1023], then voice_active[v] = 0 and the voice contributes 0.
REQ-026 Four voices each at constant 32767 -> player_sample = 32767 (saturated); all at -32768 -> -32768.
REQ-027 Tick during RD1 -> overrun = 1 and no extra valid pulse; rst asserted during MAC -> all outputs are at reset values the next cycle.
